// File: rtl/mem_responder_pkg.sv
// Shared memory-interface sizing for the main-memory responder and its array.
package mem_responder_pkg;

    localparam int unsigned MEM_ADDR_BITS   = 26;
    localparam int unsigned MEM_DATA_BITS   = 128;
    localparam int unsigned MEM_TAG_BITS    = 8;
    localparam int unsigned MEM_DATA_CYCLES = 4;
    localparam int unsigned MEM_DEPTH_BITS  = 12;
    localparam int unsigned MEM_LATENCY     = 8;

    // Beat-counter width; a one-beat line still needs a 1-bit counter.
    function automatic int unsigned beat_bits(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Single-port synchronous RAM: one read or one byte-masked write per cycle.
// The read port register returns zero on cycles without a read.
module mem_responder_array
    import mem_responder_pkg::*;
#(
    parameter int unsigned DATA_BITS  = MEM_DATA_BITS,
    parameter int unsigned DEPTH_BITS = MEM_DEPTH_BITS
) (
    input  logic                   clk,
    input  logic                   i_rd_en,
    input  logic                   i_wr_en,
    input  logic [DEPTH_BITS-1:0]  i_addr,
    input  logic [DATA_BITS-1:0]   i_wdata,
    input  logic [DATA_BITS/8-1:0] i_wmask,
    output logic [DATA_BITS-1:0]   o_rdata
);

    localparam int unsigned MASK_BITS = DATA_BITS / 8;
    localparam int unsigned DEPTH     = 2 ** DEPTH_BITS;

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [DATA_BITS-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int i = 0; i < MASK_BITS; i++) begin
                if (i_wmask[i]) begin
                    r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        r_rdata <= i_rd_en ? r_mem[i_addr] : '0;
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Main-memory responder: accepts one line read or write at a time, stores
// masked write beats and streams read beats back after a fixed latency.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = MEM_ADDR_BITS,
    parameter int unsigned DATA_BITS   = MEM_DATA_BITS,
    parameter int unsigned TAG_BITS    = MEM_TAG_BITS,
    parameter int unsigned DATA_CYCLES = MEM_DATA_CYCLES,
    parameter int unsigned DEPTH_BITS  = MEM_DEPTH_BITS,
    parameter int unsigned LATENCY     = MEM_LATENCY
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_req_valid,
    output logic                   mem_req_ready,
    input  logic                   mem_req_rw,
    input  logic [ADDR_BITS-1:0]   mem_req_addr,
    input  logic [TAG_BITS-1:0]    mem_req_tag,
    input  logic                   mem_req_data_valid,
    output logic                   mem_req_data_ready,
    input  logic [DATA_BITS-1:0]   mem_req_data_bits,
    input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
    output logic                   mem_resp_valid,
    output logic [TAG_BITS-1:0]    mem_resp_tag,
    output logic [DATA_BITS-1:0]   mem_resp_data
);

    localparam int unsigned BEAT_BITS = beat_bits(DATA_CYCLES);
    localparam int unsigned LAT_BITS  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned IDX_BITS  = ADDR_BITS + BEAT_BITS;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_RD_RESP = 2'd2;
    localparam logic [1:0] S_WR_DATA = 2'd3;

    logic [1:0]           r_state;
    logic [ADDR_BITS-1:0] r_addr;
    logic [TAG_BITS-1:0]  r_tag;
    logic [BEAT_BITS-1:0] r_beat;
    logic [LAT_BITS-1:0]  r_lat;
    logic                 r_req_ready;
    logic                 r_data_ready;
    logic                 r_resp_valid;
    logic [TAG_BITS-1:0]  r_resp_tag;

    logic [1:0]            w_state_nxt;
    logic                  w_accept;
    logic                  w_wr_beat;
    logic                  w_rd_beat;
    logic                  w_last_beat;
    logic [IDX_BITS-1:0]   w_line_idx;
    logic [DEPTH_BITS-1:0] w_idx;
    logic [DATA_BITS-1:0]  w_rdata;

    assign w_last_beat = (r_beat == BEAT_BITS'(DATA_CYCLES - 1));
    // Upper line-address bits fall off here, so lines alias modulo the array.
    assign w_line_idx  = {r_addr, r_beat};
    assign w_idx       = DEPTH_BITS'(w_line_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // RD_RESP issues one array read per beat; the beat appears on the next cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_wr_beat   = 1'b0;
        w_rd_beat   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_req_valid && r_req_ready) begin
                    w_accept = 1'b1;
                    if (mem_req_rw) begin
                        w_state_nxt = S_WR_DATA;
                    end else if (LATENCY == 1) begin
                        w_state_nxt = S_RD_RESP;
                    end else begin
                        w_state_nxt = S_RD_WAIT;
                    end
                end
            end
            S_RD_WAIT: begin
                if (r_lat == LAT_BITS'(1)) begin
                    w_state_nxt = S_RD_RESP;
                end
            end
            S_RD_RESP: begin
                w_rd_beat = 1'b1;
                if (w_last_beat) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WR_DATA: begin
                if (mem_req_data_valid && r_data_ready) begin
                    w_wr_beat = 1'b1;
                    if (w_last_beat) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (reset) begin
            w_state_nxt = S_IDLE;
            w_accept    = 1'b0;
            w_wr_beat   = 1'b0;
            w_rd_beat   = 1'b0;
        end
    end

    // Ready is held low for one cycle after the last read beat leaves.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat       <= '0;
            r_lat        <= '0;
            r_req_ready  <= 1'b0;
            r_data_ready <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_tag   <= '0;
        end else begin
            r_req_ready  <= (w_state_nxt == S_IDLE) && (r_state != S_RD_RESP);
            r_data_ready <= (w_state_nxt == S_WR_DATA);
            r_resp_valid <= w_rd_beat;
            r_resp_tag   <= w_rd_beat ? r_tag : '0;
            if (w_accept) begin
                r_beat <= '0;
                r_lat  <= LAT_BITS'(LATENCY - 1);
            end else begin
                if (r_state == S_RD_WAIT) begin
                    r_lat <= r_lat - LAT_BITS'(1);
                end
                if (w_rd_beat || w_wr_beat) begin
                    r_beat <= r_beat + BEAT_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr <= mem_req_addr;
            r_tag  <= mem_req_tag;
        end
    end

    mem_responder_array #(
        .DATA_BITS  (DATA_BITS),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_array (
        .clk     (clk),
        .i_rd_en (w_rd_beat),
        .i_wr_en (w_wr_beat),
        .i_addr  (w_idx),
        .i_wdata (mem_req_data_bits),
        .i_wmask (mem_req_data_mask),
        .o_rdata (w_rdata)
    );

    assign mem_req_ready      = r_req_ready;
    assign mem_req_data_ready = r_data_ready;
    assign mem_resp_valid     = r_resp_valid;
    assign mem_resp_tag       = r_resp_tag;
    assign mem_resp_data      = w_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: write/read, byte masks, gapped writes,
// aliasing, back-to-back reads and reset during a pending read.
module tb_mem_responder;

    localparam int unsigned AW  = 26;
    localparam int unsigned DW  = 128;
    localparam int unsigned TW  = 8;
    localparam int unsigned MW  = DW / 8;
    localparam int unsigned LAT = 8;
    localparam int unsigned DC  = 4;

    localparam logic [119:0] HI_A = 120'hDEADBEEF0123456789ABCDEF5A5A5A;
    localparam logic [119:0] HI_B = 120'h0F1E2D3C4B5A69788796A5B4C3D2E1;
    localparam logic [511:0] D_A  = {HI_A, 8'hA3, HI_A, 8'hA2, HI_A, 8'hA1, HI_A, 8'hA0};
    localparam logic [511:0] D_B  = {HI_B, 8'hB3, HI_B, 8'hB2, HI_B, 8'hB1, HI_B, 8'hB0};
    localparam logic [511:0] D_G  = {96'h0, 32'hC0DE0003, 96'h0, 32'hC0DE0002,
                                     96'h0, 32'hC0DE0001, 96'h0, 32'hC0DE0000};
    localparam logic [511:0] D_ONES     = {512{1'b1}};
    localparam logic [511:0] D_ZERO     = '0;
    localparam logic [511:0] EXP_MASKED = {{504{1'b1}}, 8'h00};
    localparam logic [63:0]  M_ALL      = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0]  M_BYTE0    = 64'h0000_0000_0000_0001;

    logic          clk;
    logic          reset;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_rw;
    logic [AW-1:0] mem_req_addr;
    logic [TW-1:0] mem_req_tag;
    logic          mem_req_data_valid;
    logic          mem_req_data_ready;
    logic [DW-1:0] mem_req_data_bits;
    logic [MW-1:0] mem_req_data_mask;
    logic          mem_resp_valid;
    logic [TW-1:0] mem_resp_tag;
    logic [DW-1:0] mem_resp_data;

    int n_vec;
    int n_miss;

    mem_responder #(
        .ADDR_BITS   (AW),
        .DATA_BITS   (DW),
        .TAG_BITS    (TW),
        .DATA_CYCLES (DC),
        .DEPTH_BITS  (12),
        .LATENCY     (LAT)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_rw         (mem_req_rw),
        .mem_req_addr       (mem_req_addr),
        .mem_req_tag        (mem_req_tag),
        .mem_req_data_valid (mem_req_data_valid),
        .mem_req_data_ready (mem_req_data_ready),
        .mem_req_data_bits  (mem_req_data_bits),
        .mem_req_data_mask  (mem_req_data_mask),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_tag       (mem_resp_tag),
        .mem_resp_data      (mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive after the edge settles; samples here see that edge's register updates.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!mem_req_ready && cycles < 50) begin
            tick();
            cycles++;
        end
        check_val("req_ready_wait", 128'(mem_req_ready), 128'(1));
    endtask

    task automatic write_line(input logic [AW-1:0] addr, input logic [511:0] data,
                              input logic [63:0] mask, input bit gap);
        int w;
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = addr;
        wait_ready(w);
        tick();
        mem_req_valid = 1'b0;
        check_val("wr_data_ready", 128'(mem_req_data_ready), 128'(1));
        for (int b = 0; b < DC; b++) begin
            check_val("wr_ready_busy", 128'(mem_req_ready), 128'(0));
            mem_req_data_valid = 1'b1;
            mem_req_data_bits  = data[b*DW +: DW];
            mem_req_data_mask  = mask[b*MW +: MW];
            tick();
            if (gap && b == 1) begin
                // Idle data cycles with a competing request that must not be taken.
                mem_req_data_valid = 1'b0;
                mem_req_valid      = 1'b1;
                mem_req_rw         = 1'b0;
                for (int g = 0; g < 2; g++) begin
                    tick();
                    check_val("gap_req_ready", 128'(mem_req_ready), 128'(0));
                    check_val("gap_data_ready", 128'(mem_req_data_ready), 128'(1));
                end
                mem_req_valid = 1'b0;
            end
        end
        mem_req_data_valid = 1'b0;
        check_val("wr_done_ready", 128'(mem_req_ready), 128'(1));
        check_val("wr_done_data_ready", 128'(mem_req_data_ready), 128'(0));
    endtask

    task automatic read_line(input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                             input logic [511:0] exp, input bit b2b);
        int w;
        int early;
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = addr;
        mem_req_tag   = tag;
        wait_ready(w);
        if (b2b) check_val("b2b_accept_wait", 128'(w), 128'(0));
        tick();
        mem_req_valid = 1'b0;
        early = 0;
        for (int k = 1; k < LAT; k++) begin
            tick();
            if (mem_resp_valid || mem_resp_data != '0 || mem_resp_tag != '0) early++;
        end
        check_val("rd_quiet_before_latency", 128'(early), 128'(0));
        for (int b = 0; b < DC; b++) begin
            tick();
            check_val("rd_resp_valid", 128'(mem_resp_valid), 128'(1));
            check_val("rd_resp_data", mem_resp_data, exp[b*DW +: DW]);
            check_val("rd_resp_tag", 128'(mem_resp_tag), 128'(tag));
            if (b == DC - 1) check_val("rd_last_ready", 128'(mem_req_ready), 128'(0));
        end
        tick();
        check_val("rd_after_valid", 128'(mem_resp_valid), 128'(0));
        check_val("rd_after_ready", 128'(mem_req_ready), 128'(1));
    endtask

    initial begin
        int w;
        int seen;
        n_vec              = 0;
        n_miss             = 0;
        reset              = 1'b1;
        mem_req_valid      = 1'b0;
        mem_req_rw         = 1'b0;
        mem_req_addr       = '0;
        mem_req_tag        = '0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = '0;
        mem_req_data_mask  = '0;

        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("rst_req_ready", 128'(mem_req_ready), 128'(0));
            check_val("rst_resp_valid", 128'(mem_resp_valid), 128'(0));
            check_val("rst_data_ready", 128'(mem_req_data_ready), 128'(0));
        end
        reset = 1'b0;
        tick();
        check_val("post_rst_ready", 128'(mem_req_ready), 128'(1));
        check_val("post_rst_resp_data", mem_resp_data, 128'(0));

        write_line(26'h5, D_A, M_ALL, 1'b0);
        read_line(26'h5, 8'h13, D_A, 1'b0);

        write_line(26'h2, D_ONES, M_ALL, 1'b0);
        write_line(26'h2, D_ZERO, M_BYTE0, 1'b0);
        read_line(26'h2, 8'h05, EXP_MASKED, 1'b0);

        write_line(26'h7, D_G, M_ALL, 1'b1);
        read_line(26'h7, 8'h07, D_G, 1'b0);

        write_line(26'h400, D_B, M_ALL, 1'b0);
        read_line(26'h000, 8'h40, D_B, 1'b0);
        read_line(26'h400, 8'h41, D_B, 1'b1);

        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = 26'h5;
        mem_req_tag   = 8'h2A;
        wait_ready(w);
        tick();
        mem_req_valid = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        check_val("midrd_rst_ready", 128'(mem_req_ready), 128'(0));
        reset = 1'b0;
        tick();
        check_val("midrd_post_ready", 128'(mem_req_ready), 128'(1));
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (mem_resp_valid) seen++;
            tick();
        end
        check_val("midrd_no_resp", 128'(seen), 128'(0));
        read_line(26'h5, 8'h31, D_A, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
